// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// It generates the forwarding selects, the load-use and branch stalls, and the
// branch flush. A data-memory wait FSM freezes the whole pipeline while a
// load/store in Memory is not acknowledged, and aborts after MEM_TIMEOUT cycles.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall/flush cycle counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned RF_ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT_W     = 4,
  parameter int unsigned MEM_TIMEOUT   = 12
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsE,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic                     i_RegWriteE,
  input  logic                     i_RegWriteM,
  input  logic                     i_RegWriteW,
  input  logic [1:0]               i_MemtoRegE,
  input  logic [1:0]               i_MemtoRegM,
  input  logic                     i_BranchD,
  input  logic                     i_PCSrcD,
  input  logic                     i_MemReqM,
  input  logic                     i_MemReadyM,
  output logic                     o_StallF,
  output logic                     o_StallD,
  output logic                     o_StallE,
  output logic                     o_StallM,
  output logic                     o_FlushD,
  output logic                     o_FlushE,
  output logic                     o_FlushW,
  output logic [1:0]               o_ForwardAE,
  output logic [1:0]               o_ForwardBE,
  output logic                     o_ForwardAD,
  output logic                     o_ForwardBD,
  output logic                     o_MemErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]              o_StallCnt,
  output logic [31:0]              o_FlushCnt
`endif
);

  localparam logic [TIMEOUT_W-1:0] TimeoutVal = TIMEOUT_W'(MEM_TIMEOUT);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                 mem_err_q, mem_err_d;
  logic                 lw_stall, br_stall, mem_stall;

  // Forwarding selects; the Memory stage is younger and beats Writeback on a tie.
  always_comb begin
    o_ForwardAE = 2'b00;
    if ((i_RsE != '0) && i_RegWriteM && (i_WriteRegM == i_RsE)) begin
      o_ForwardAE = 2'b10;
    end else if ((i_RsE != '0) && i_RegWriteW && (i_WriteRegW == i_RsE)) begin
      o_ForwardAE = 2'b01;
    end
    o_ForwardBE = 2'b00;
    if ((i_RtE != '0) && i_RegWriteM && (i_WriteRegM == i_RtE)) begin
      o_ForwardBE = 2'b10;
    end else if ((i_RtE != '0) && i_RegWriteW && (i_WriteRegW == i_RtE)) begin
      o_ForwardBE = 2'b01;
    end
    o_ForwardAD = (i_RsD != '0) && i_RegWriteM && (i_WriteRegM == i_RsD);
    o_ForwardBD = (i_RtD != '0) && i_RegWriteM && (i_WriteRegM == i_RtD);
  end

  // Load-use and branch-operand hazards detected in Decode.
  always_comb begin
    lw_stall = (i_MemtoRegE == 2'b01) && ((i_RtE == i_RsD) || (i_RtE == i_RtD));
    br_stall = i_BranchD &&
               ((i_RegWriteE && ((i_WriteRegE == i_RsD) || (i_WriteRegE == i_RtD))) ||
                ((i_MemtoRegM == 2'b01) &&
                 ((i_WriteRegM == i_RsD) || (i_WriteRegM == i_RtD))));
  end

  // Memory-wait FSM state, wait counter and sticky error flag.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Memory-wait FSM next state.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      StRun: begin
        if (i_MemReqM && !i_MemReadyM) begin
          state_d    = StMemWait;
          wait_cnt_d = TIMEOUT_W'(1);
        end
      end
      StMemWait: begin
        if (i_MemReadyM) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TimeoutVal) begin
          // Give up on the access; the pipeline resumes and the error latches.
          state_d    = StRun;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TIMEOUT_W'(1);
        end
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Stall/flush outputs; a memory freeze overrides load-use and branch stalls.
  always_comb begin
    mem_stall = ((state_q == StRun) && i_MemReqM && !i_MemReadyM) ||
                ((state_q == StMemWait) && !i_MemReadyM && (wait_cnt_q != TimeoutVal));
    o_StallF = 1'b0;
    o_StallD = 1'b0;
    o_StallE = 1'b0;
    o_StallM = 1'b0;
    o_FlushE = 1'b0;
    o_FlushW = 1'b0;
    if (!i_RST) begin
      // Everything held quiet while in reset; FlushD follows StallD below.
      o_StallF = 1'b0;
    end else if (mem_stall) begin
      o_StallF = 1'b1;
      o_StallD = 1'b1;
      o_StallE = 1'b1;
      o_StallM = 1'b1;
      o_FlushW = 1'b1;
    end else if (lw_stall || br_stall) begin
      o_StallF = 1'b1;
      o_StallD = 1'b1;
      o_FlushE = 1'b1;
    end
    // A stalled Decode defers the branch flush until the stall clears.
    o_FlushD = i_RST && i_PCSrcD && !o_StallD;
  end

  assign o_MemErr = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters of stalled cycles and flushing cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((o_StallF || o_StallD || o_StallE || o_StallM) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if ((o_FlushD || o_FlushE) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_StallCnt = stall_cnt_q;
  assign o_FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Define HAZARD_PERF_CNT_EN for both files to also exercise the perf counters.
module tb_pipeline_hazard_ctrl;

  localparam int MemTimeout = 12;

  logic       clk, rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic       rw_e, rw_m, rw_w;
  logic [1:0] m2r_e, m2r_m;
  logic       branch_d, pcsrc_d, mem_req, mem_ready;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic [1:0] fwd_ae, fwd_be;
  logic       fwd_ad, fwd_bd, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  logic [6:0] sf;
  assign sf = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

  int checks = 0;
  int passed = 0;

  pipeline_hazard_ctrl #(
    .RF_ADDR_WIDTH(5),
    .TIMEOUT_W    (4),
    .MEM_TIMEOUT  (MemTimeout)
  ) dut (
    .i_CLK       (clk),
    .i_RST       (rst_n),
    .i_RsD       (rs_d),
    .i_RtD       (rt_d),
    .i_RsE       (rs_e),
    .i_RtE       (rt_e),
    .i_WriteRegE (wr_e),
    .i_WriteRegM (wr_m),
    .i_WriteRegW (wr_w),
    .i_RegWriteE (rw_e),
    .i_RegWriteM (rw_m),
    .i_RegWriteW (rw_w),
    .i_MemtoRegE (m2r_e),
    .i_MemtoRegM (m2r_m),
    .i_BranchD   (branch_d),
    .i_PCSrcD    (pcsrc_d),
    .i_MemReqM   (mem_req),
    .i_MemReadyM (mem_ready),
    .o_StallF    (stall_f),
    .o_StallD    (stall_d),
    .o_StallE    (stall_e),
    .o_StallM    (stall_m),
    .o_FlushD    (flush_d),
    .o_FlushE    (flush_e),
    .o_FlushW    (flush_w),
    .o_ForwardAE (fwd_ae),
    .o_ForwardBE (fwd_be),
    .o_ForwardAD (fwd_ad),
    .o_ForwardBD (fwd_bd),
    .o_MemErr    (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .o_StallCnt  (stall_cnt),
    .o_FlushCnt  (flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    wr_e = '0; wr_m = '0; wr_w = '0;
    rw_e = 1'b0; rw_m = 1'b0; rw_w = 1'b0;
    m2r_e = 2'b00; m2r_m = 2'b00;
    branch_d = 1'b0; pcsrc_d = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Inputs change on the falling edge; outputs are sampled 2ns later.
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_req = 1'b1; mem_ready = 1'b0; pcsrc_d = 1'b1;
    m2r_e = 2'b01; rt_e = 5'd5; rs_d = 5'd5;
    rs_e = 5'd3; rw_m = 1'b1; wr_m = 5'd3;
    #2;
    checks++;
    if (sf !== 7'b0000000) $display("FAIL reset_stall_flush: got %b want 0000000", sf);
    else passed++;
    checks++;
    if (mem_err !== 1'b0) $display("FAIL reset_memerr: got %b want 0", mem_err);
    else passed++;
    checks++;
    if (fwd_ae !== 2'b10) $display("FAIL reset_fwd_comb: got %b want 10", fwd_ae);
    else passed++;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    @(negedge clk);
    clear_inputs();
    rs_e = 5'd3; rw_m = 1'b1; wr_m = 5'd3; rw_w = 1'b1; wr_w = 5'd3;
    #2;
    checks++;
    if (fwd_ae !== 2'b10) $display("FAIL fwd_ae_mem_tie: got %b want 10", fwd_ae);
    else passed++;
    rs_e = 5'd0; wr_m = 5'd0; wr_w = 5'd0;
    #1;
    checks++;
    if (fwd_ae !== 2'b00) $display("FAIL fwd_ae_r0: got %b want 00", fwd_ae);
    else passed++;
    rs_e = 5'd4; rw_m = 1'b0; wr_m = 5'd4; rw_w = 1'b1; wr_w = 5'd4;
    #1;
    checks++;
    if (fwd_ae !== 2'b01) $display("FAIL fwd_ae_wb: got %b want 01", fwd_ae);
    else passed++;
    rs_e = 5'd0; rt_e = 5'd6; rw_m = 1'b1; wr_m = 5'd6; rw_w = 1'b1; wr_w = 5'd6;
    #1;
    checks++;
    if (fwd_be !== 2'b10) $display("FAIL fwd_be_mem: got %b want 10", fwd_be);
    else passed++;
    wr_m = 5'd5;
    #1;
    checks++;
    if (fwd_be !== 2'b01) $display("FAIL fwd_be_wb: got %b want 01", fwd_be);
    else passed++;
    rt_e = 5'd0; rs_d = 5'd9; rt_d = 5'd8; wr_m = 5'd9; rw_w = 1'b0;
    #1;
    checks++;
    if ({fwd_ad, fwd_bd} !== 2'b10) $display("FAIL fwd_ad: got %b want 10", {fwd_ad, fwd_bd});
    else passed++;
    rs_d = 5'd0; rt_d = 5'd0; wr_m = 5'd0;
    #1;
    checks++;
    if ({fwd_ad, fwd_bd} !== 2'b00) $display("FAIL fwd_d_r0: got %b want 00", {fwd_ad, fwd_bd});
    else passed++;
  endtask

  task automatic test_lwstall();
    @(negedge clk);
    clear_inputs();
    m2r_e = 2'b01; rt_e = 5'd5; rs_d = 5'd5; pcsrc_d = 1'b1;
    #2;
    checks++;
    if (sf !== 7'b1100010) $display("FAIL lwstall: got %b want 1100010", sf);
    else passed++;
    // The load has moved on; the deferred branch flush now goes out.
    @(negedge clk);
    m2r_e = 2'b00; rt_e = 5'd0;
    #2;
    checks++;
    if (sf !== 7'b0000100) $display("FAIL lw_deferred_flush: got %b want 0000100", sf);
    else passed++;
  endtask

  task automatic test_brstall();
    @(negedge clk);
    clear_inputs();
    branch_d = 1'b1; rw_e = 1'b1; wr_e = 5'd7; rt_d = 5'd7; rs_d = 5'd2;
    #2;
    checks++;
    if (sf !== 7'b1100010) $display("FAIL brstall_e: got %b want 1100010", sf);
    else passed++;
    @(negedge clk);
    rw_e = 1'b0; wr_e = 5'd0; rw_m = 1'b1; wr_m = 5'd7;
    #2;
    checks++;
    if ({sf, fwd_ad, fwd_bd} !== 9'b0000000_01)
      $display("FAIL br_fwd_m: got %b want 000000001", {sf, fwd_ad, fwd_bd});
    else passed++;
    // Load in Memory feeding the branch still stalls.
    @(negedge clk);
    m2r_m = 2'b01; wr_m = 5'd2;
    #2;
    checks++;
    if (sf !== 7'b1100010) $display("FAIL brstall_load_m: got %b want 1100010", sf);
    else passed++;
  endtask

  task automatic test_memwait();
    @(negedge clk);
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      mem_req = 1'b1; mem_ready = 1'b0; pcsrc_d = 1'b1;
      m2r_e = 2'b01; rt_e = 5'd5; rs_d = 5'd5;
      #2;
      checks++;
      if (sf !== 7'b1111001) $display("FAIL memwait_cyc%0d: got %b want 1111001", i, sf);
      else passed++;
      @(negedge clk);
    end
    clear_inputs();
    mem_req = 1'b1; mem_ready = 1'b1;
    #2;
    checks++;
    if (sf !== 7'b0000000) $display("FAIL memwait_ack: got %b want 0000000", sf);
    else passed++;
    @(negedge clk);
    clear_inputs();
    #2;
    checks++;
    if ({sf, mem_err} !== 8'b0) $display("FAIL memwait_run: got %b want 00000000", {sf, mem_err});
    else passed++;
  endtask

  task automatic test_timeout();
    int stall_cycles;
    @(negedge clk);
    clear_inputs();
    mem_req = 1'b1;
    stall_cycles = 0;
    for (int i = 0; i < MemTimeout; i++) begin
      #2;
      if (stall_m === 1'b1) stall_cycles++;
      @(negedge clk);
    end
    checks++;
    if (stall_cycles != MemTimeout)
      $display("FAIL timeout_stall_cycles: got %0d want %0d", stall_cycles, MemTimeout);
    else passed++;
    #2;
    checks++;
    if ({sf, mem_err} !== 8'b0) $display("FAIL timeout_abort: got %b want 00000000", {sf, mem_err});
    else passed++;
    @(negedge clk);
    mem_req = 1'b0;
    #2;
    checks++;
    if (mem_err !== 1'b1) $display("FAIL timeout_memerr: got %b want 1", mem_err);
    else passed++;
    @(negedge clk);
    mem_req = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    #2;
    checks++;
    if (mem_err !== 1'b1) $display("FAIL memerr_sticky: got %b want 1", mem_err);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_err !== 1'b0) $display("FAIL memerr_reset: got %b want 0", mem_err);
    else passed++;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    clear_inputs();
    mem_req = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #2;
    checks++;
    if (sf !== 7'b0000000) $display("FAIL mid_wait_reset_out: got %b want 0000000", sf);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    // Ready still low: a lingering wait state would keep stalling here.
    mem_req = 1'b0; mem_ready = 1'b0;
    #2;
    checks++;
    if ({sf, mem_err} !== 8'b0) $display("FAIL mid_wait_run: got %b want 00000000", {sf, mem_err});
    else passed++;
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    @(negedge clk);
    m2r_e = 2'b01; rt_e = 5'd5; rs_d = 5'd5;
    @(negedge clk);
    clear_inputs();
    pcsrc_d = 1'b1;
    @(negedge clk);
    clear_inputs();
    #2;
    checks++;
    if (stall_cnt !== 32'd1) $display("FAIL perf_stall_cnt: got %0d want 1", stall_cnt);
    else passed++;
    checks++;
    if (flush_cnt !== 32'd2) $display("FAIL perf_flush_cnt: got %0d want 2", flush_cnt);
    else passed++;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_forward();
    test_lwstall();
    test_brstall();
    test_memwait();
    test_timeout();
    test_reset_mid_wait();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    do_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
